// File: rtl/dpc_detector_test.sv
// dpc_detector_test: streaming 3x3 dead/stuck pixel detector over a per-pixel k map.
// Optional bad-pixel list RAM and read port are built when DPC_BP_LIST_EN is defined.
module dpc_detector_test #(
    parameter int WIDTH         = 16,
    parameter int K_WIDTH       = 16,
    parameter int CNT_WIDTH     = 10,
    parameter int MANUAL_BP_NUM = 128,
    parameter int MANUAL_BP_BIT = 7,
    parameter int AUTO_BP_NUM   = 256,
    parameter int AUTO_BP_BIT   = 8,
    parameter int THRESHOLD     = 50,
    parameter int FRAME_HEIGHT  = 10,
    parameter int FRAME_WIDTH   = 10
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [WIDTH-1:0]       s_axis_tdata,
    input  logic                   s_axis_tuser,
    input  logic                   s_axis_tlast,
    input  logic                   k_axis_tvalid,
    input  logic [K_WIDTH-1:0]     k_axis_tdata,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tvalid,
    output logic [WIDTH-1:0]       m_axis_tdata,
    output logic                   m_axis_tuser,
    output logic                   m_axis_tlast,
    output logic [WIDTH-1:0]       w11,
    output logic [WIDTH-1:0]       w12,
    output logic [WIDTH-1:0]       w13,
    output logic [WIDTH-1:0]       w21,
    output logic [WIDTH-1:0]       w23,
    output logic [WIDTH-1:0]       w31,
    output logic [WIDTH-1:0]       w32,
    output logic [WIDTH-1:0]       w33,
    output logic                   k_out_tvalid,
    output logic [K_WIDTH:0]       k_out_tdata,
    output logic                   k11_vld,
    output logic                   k12_vld,
    output logic                   k13_vld,
    output logic                   k21_vld,
    output logic                   k23_vld,
    output logic                   k31_vld,
    output logic                   k32_vld,
    output logic                   k33_vld,
    input  logic                   enable,
    input  logic [K_WIDTH-1:0]     k_threshold,
    output logic                   auto_bp_valid,
    output logic [CNT_WIDTH-1:0]   auto_bp_x,
    output logic [CNT_WIDTH-1:0]   auto_bp_y,
    input  logic [AUTO_BP_BIT-1:0] auto_bp_read_addr,
    output logic [31:0]            auto_bp_read_data,
    output logic                   frame_detection_done,
    output logic [AUTO_BP_BIT-1:0] detected_bp_count
);
    localparam int E = WIDTH + K_WIDTH;
    localparam int D = 2 * FRAME_WIDTH + 2;
    localparam logic [CNT_WIDTH-1:0] XL = CNT_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] YL = CNT_WIDTH'(FRAME_HEIGHT - 1);
    localparam logic [CNT_WIDTH-1:0] FL = CNT_WIDTH'(FRAME_WIDTH);
    localparam logic [AUTO_BP_BIT-1:0] SAT = AUTO_BP_BIT'(AUTO_BP_NUM - 1);

    if (AUTO_BP_NUM > 2 ** AUTO_BP_BIT || MANUAL_BP_NUM > 2 ** MANUAL_BP_BIT || FRAME_WIDTH < 2) begin : g_cfg
        $error("dpc_detector_test: inconsistent parameters");
    end

    // lb[i] holds the pixel accepted i+1 beats ago: two lines plus two pixels of history
    logic [E-1:0]           lb [0:D-1];
    logic [E-1:0]           nb [0:7];
    logic [E-1:0]           din, ctr;
    logic [WIDTH-1:0]       wr [0:7];
    logic [K_WIDTH:0]       diff [0:7];
    logic [K_WIDTH-1:0]     thr, kc, kc_q;
    logic [CNT_WIDTH-1:0]   in_x, in_y, px, py, cx, cy, fcnt;
    logic [7:0]             inf, vld, far, kv;
    logic                   flush, fstep, accept, adv, eol, emit, bad, det, last_emit, kflag;
    logic                   top, bot, lft, rgt;

    assign s_axis_tready = m_axis_tready && !flush && !areset;
    assign accept = s_axis_tvalid && s_axis_tready;
    assign fstep = flush && m_axis_tready && !areset;
    assign adv = accept || fstep;
    assign px = s_axis_tuser ? '0 : in_x;
    assign py = s_axis_tuser ? '0 : in_y;
    assign eol = px == XL || s_axis_tlast;
    // the centre trails the newest pixel by one line plus one pixel
    assign emit = fstep || (accept && (py > 1 || (py == 1 && px != 0)));
    assign din = {s_axis_tdata, k_axis_tvalid ? k_axis_tdata : '0};
    assign ctr = lb[FRAME_WIDTH];
    assign kc = ctr[K_WIDTH-1:0];
    assign thr = k_threshold == '0 ? K_WIDTH'(THRESHOLD) : k_threshold;
    assign top = cy != '0;
    assign bot = cy != YL;
    assign lft = cx != '0;
    assign rgt = cx != XL;
    assign inf = {bot & rgt, bot, bot & lft, rgt, lft, top & rgt, top, top & lft};

    always_comb begin
        nb[0] = lb[D-1];
        nb[1] = lb[D-2];
        nb[2] = lb[D-3];
        nb[3] = lb[FRAME_WIDTH+1];
        nb[4] = lb[FRAME_WIDTH-1];
        nb[5] = lb[1];
        nb[6] = lb[0];
        nb[7] = accept ? din : '0;
        vld = '0;
        far = '0;
        for (int i = 0; i < 8; i++) begin
            vld[i] = inf[i] && nb[i][K_WIDTH-1:0] != '0;
            diff[i] = {1'b0, kc} - {1'b0, nb[i][K_WIDTH-1:0]};
            far[i] = (diff[i][K_WIDTH] ? -diff[i] : diff[i]) > {1'b0, thr};
        end
        bad = kc == '0 || (|vld && &(far | ~vld));
    end

    assign det = emit && bad && enable;
    assign {w11, w12, w13, w21, w23, w31, w32, w33} = {wr[0], wr[1], wr[2], wr[3], wr[4], wr[5], wr[6], wr[7]};
    assign {k11_vld, k12_vld, k13_vld, k21_vld, k23_vld, k31_vld, k32_vld, k33_vld} =
        {kv[0], kv[1], kv[2], kv[3], kv[4], kv[5], kv[6], kv[7]};
    assign k_out_tvalid = m_axis_tvalid;
    assign k_out_tdata = {kflag, kc_q};

    always_ff @(posedge aclk) begin
        if (adv) begin
            lb[0] <= nb[7];
            for (int i = 1; i < D; i++) lb[i] <= lb[i-1];
            m_axis_tdata <= ctr[E-1:K_WIDTH];
            kc_q <= kc;
            for (int i = 0; i < 8; i++) wr[i] <= inf[i] ? nb[i][E-1:K_WIDTH] : '0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            in_x <= '0;
            in_y <= '0;
            cx <= '0;
            cy <= '0;
            fcnt <= '0;
            flush <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tuser <= 1'b0;
            m_axis_tlast <= 1'b0;
            kflag <= 1'b0;
            kv <= '0;
            auto_bp_valid <= 1'b0;
            auto_bp_x <= '0;
            auto_bp_y <= '0;
            last_emit <= 1'b0;
            frame_detection_done <= 1'b0;
            detected_bp_count <= '0;
        end else begin
            auto_bp_valid <= det;
            last_emit <= emit && cx == XL && cy == YL;
            if (last_emit) frame_detection_done <= 1'b1;
            if (det && detected_bp_count != SAT) detected_bp_count <= detected_bp_count + 1'b1;
            if (emit) begin
                cx <= cx == XL ? '0 : cx + 1'b1;
                cy <= cx == XL ? (cy == YL ? '0 : cy + 1'b1) : cy;
            end
            if (fstep) begin
                fcnt <= fcnt + 1'b1;
                if (fcnt == FL) flush <= 1'b0;
            end
            if (accept) begin
                in_x <= eol ? '0 : px + 1'b1;
                in_y <= eol ? (py == YL ? '0 : py + 1'b1) : py;
                if (eol && py == YL) begin
                    flush <= 1'b1;
                    fcnt <= '0;
                end
                if (s_axis_tuser) begin
                    cx <= '0;
                    cy <= '0;
                    frame_detection_done <= 1'b0;
                    detected_bp_count <= '0;
                end
            end
            if (adv) begin
                m_axis_tvalid <= emit;
                m_axis_tuser <= cx == '0 && cy == '0;
                m_axis_tlast <= cx == XL;
                kflag <= det;
                kv <= vld;
                auto_bp_x <= cx;
                auto_bp_y <= cy;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

`ifdef DPC_BP_LIST_EN
    logic [2*CNT_WIDTH-1:0] list [0:AUTO_BP_NUM-1];
    logic [2*CNT_WIDTH-1:0] rd;
    assign rd = list[auto_bp_read_addr];
    always_ff @(posedge aclk) begin
        if (det && detected_bp_count != SAT) list[detected_bp_count] <= {cy, cx};
        auto_bp_read_data <= {16'(rd[2*CNT_WIDTH-1:CNT_WIDTH]), 16'(rd[CNT_WIDTH-1:0])};
    end
`else
    // no list is kept, so the read address has nothing to select
    assign auto_bp_read_data = 32'(auto_bp_read_addr) & 32'h0;
`endif
endmodule

// File: tb/tb_dpc_detector_test.sv
// tb_dpc_detector_test: randomized frames checked against a per-pixel behavioural model.
`timescale 1ns/1ps
module tb_dpc_detector_test;
    localparam int W = 10, H = 10, BW = 172;

    logic aclk = 1'b0, areset = 1'b1;
    logic s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tuser = 1'b0, s_axis_tlast = 1'b0;
    logic [15:0] s_axis_tdata = '0, k_axis_tdata = '0, k_threshold = '0;
    logic k_axis_tvalid = 1'b1, m_axis_tready, m_axis_tvalid, m_axis_tuser, m_axis_tlast;
    logic [15:0] m_axis_tdata, w11, w12, w13, w21, w23, w31, w32, w33;
    logic k_out_tvalid, k11_vld, k12_vld, k13_vld, k21_vld, k23_vld, k31_vld, k32_vld, k33_vld;
    logic [16:0] k_out_tdata;
    logic enable = 1'b1, auto_bp_valid, frame_detection_done;
    logic [9:0] auto_bp_x, auto_bp_y;
    logic [7:0] auto_bp_read_addr = '0, detected_bp_count;
    logic [31:0] auto_bp_read_data;

    int checks = 0, errors = 0, rmode = 0, cyc = 0;
    int pix [H][W];
    int kk [H][W];
    logic [BW-1:0] got_q[$], exp_q[$];
    logic [19:0] det_q[$], exp_det[$];

    always #5 aclk = ~aclk;

    dpc_detector_test dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
        .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
        .k_axis_tvalid(k_axis_tvalid), .k_axis_tdata(k_axis_tdata),
        .m_axis_tready(m_axis_tready), .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
        .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .w11(w11), .w12(w12), .w13(w13), .w21(w21), .w23(w23), .w31(w31), .w32(w32), .w33(w33),
        .k_out_tvalid(k_out_tvalid), .k_out_tdata(k_out_tdata),
        .k11_vld(k11_vld), .k12_vld(k12_vld), .k13_vld(k13_vld), .k21_vld(k21_vld),
        .k23_vld(k23_vld), .k31_vld(k31_vld), .k32_vld(k32_vld), .k33_vld(k33_vld),
        .enable(enable), .k_threshold(k_threshold),
        .auto_bp_valid(auto_bp_valid), .auto_bp_x(auto_bp_x), .auto_bp_y(auto_bp_y),
        .auto_bp_read_addr(auto_bp_read_addr), .auto_bp_read_data(auto_bp_read_data),
        .frame_detection_done(frame_detection_done), .detected_bp_count(detected_bp_count)
    );

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            cyc++;
            m_axis_tready = rmode == 0 ? 1'b1 : rmode == 1 ? (cyc % 3 != 0) : ($urandom_range(0, 3) != 0);
        end
    end

    always @(negedge aclk) begin
        if (m_axis_tvalid && m_axis_tready)
            got_q.push_back({m_axis_tdata, m_axis_tuser, m_axis_tlast, k_out_tvalid, k_out_tdata,
                             w11, w12, w13, w21, w23, w31, w32, w33,
                             k11_vld, k12_vld, k13_vld, k21_vld, k23_vld, k31_vld, k32_vld, k33_vld});
        if (auto_bp_valid) det_q.push_back({auto_bp_y, auto_bp_x});
    end

    // bit0: dead pixel at (2,3); bit1: stuck k at (6,4) and (8,7); bit2: random image
    task automatic build(input int mode);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                pix[y][x] = 1000 + 100 * y + 10 * x;
                kk[y][x] = pix[y][x] + $urandom_range(0, 20) - 10;
                if (mode & 4) begin
                    pix[y][x] = $urandom_range(0, 65535);
                    kk[y][x] = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 3000);
                end
            end
        if (mode & 1) begin
            pix[3][2] = 0;
            kk[3][2] = 0;
        end
        if (mode & 2) begin
            kk[4][6] = 2080;
            kk[7][8] = 420;
        end
    endtask

    task automatic model(input bit en, input int thr);
        int t, ny, nx, nd, nk, nv, d;
        bit in, v, allfar, bad;
        logic [127:0] wv;
        logic [7:0] kv;
        exp_q.delete();
        exp_det.delete();
        t = thr == 0 ? 50 : thr;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                wv = '0;
                kv = '0;
                nv = 0;
                allfar = 1;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if (dy != 0 || dx != 0) begin
                            ny = y + dy;
                            nx = x + dx;
                            in = ny >= 0 && ny < H && nx >= 0 && nx < W;
                            nd = in ? pix[ny][nx] : 0;
                            nk = in ? kk[ny][nx] : 0;
                            v = in && nk != 0;
                            wv = {wv[111:0], 16'(nd)};
                            kv = {kv[6:0], v};
                            if (v) begin
                                nv++;
                                d = kk[y][x] - nk;
                                if (d < 0) d = -d;
                                if (d <= t) allfar = 0;
                            end
                        end
                bad = kk[y][x] == 0 || (nv > 0 && allfar);
                exp_q.push_back({16'(pix[y][x]), x == 0 && y == 0, x == W - 1, 1'b1,
                                 bad && en, 16'(kk[y][x]), wv, kv});
                if (bad && en) exp_det.push_back({10'(y), 10'(x)});
            end
    endtask

    task automatic send_px(input int x, input int y);
        int n = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata = 16'(pix[y][x]);
        k_axis_tdata = 16'(kk[y][x]);
        s_axis_tuser = x == 0 && y == 0;
        s_axis_tlast = x == W - 1;
        @(negedge aclk);
        while (!s_axis_tready && n < 200) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 200) check("s_ready_wait", 0, 1);
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic run_frame(input int mode, input bit en, input int thr, input int rm);
        int n = 0;
        logic [31:0] rexp;
        rmode = rm;
        build(mode);
        enable = en;
        k_threshold = 16'(thr);
        model(en, thr);
        got_q.delete();
        det_q.delete();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) send_px(x, y);
        check("flush_ready", s_axis_tready, 0);
        while (!frame_detection_done && n < 400) begin
            @(negedge aclk);
            n++;
        end
        check("done", frame_detection_done, 1);
        repeat (12) @(negedge aclk);
        rmode = 0;
        check("beats", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size()) check($sformatf("beat%0d", i), got_q[i], exp_q[i]);
        check("ndet", det_q.size(), exp_det.size());
        for (int i = 0; i < exp_det.size(); i++)
            if (i < det_q.size()) check($sformatf("det%0d", i), det_q[i], exp_det[i]);
        check("count", detected_bp_count, exp_det.size());
        for (int i = 0; i < exp_det.size() && i < 8; i++) begin
            @(posedge aclk);
            #1;
            auto_bp_read_addr = 8'(i);
            @(posedge aclk);
            #1;
`ifdef DPC_BP_LIST_EN
            rexp = {16'(exp_det[i][19:10]), 16'(exp_det[i][9:0])};
`else
            rexp = '0;
`endif
            check($sformatf("list%0d", i), auto_bp_read_data, rexp);
        end
    endtask

    initial begin
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_ready", s_axis_tready, 0);
        check("rst_mvalid", m_axis_tvalid, 0);
        check("rst_bpvalid", auto_bp_valid, 0);
        check("rst_count", detected_bp_count, 0);
        check("rst_done", frame_detection_done, 0);
        check("rst_kout", k_out_tdata, 0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        check("ready_after_rst", s_axis_tready, 1);
        @(posedge aclk);
        #1;

        run_frame(0, 1'b1, 0, 0);
        run_frame(1, 1'b1, 50, 0);
        run_frame(3, 1'b1, 50, 0);
        run_frame(3, 1'b1, 50, 1);
        run_frame(3, 1'b0, 50, 0);
        run_frame(4, 1'b1, $urandom_range(0, 400), 2);
        run_frame(7, 1'b1, $urandom_range(0, 400), 2);

        build(3);
        enable = 1'b1;
        k_threshold = 16'd50;
        for (int p = 0; p < 45; p++) send_px(p % W, p / W);
        @(negedge aclk);
        check("pre_rst_count", detected_bp_count, 1);
        @(posedge aclk);
        #1;
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("mid_rst_mvalid", m_axis_tvalid, 0);
        check("mid_rst_count", detected_bp_count, 0);
        check("mid_rst_ready", s_axis_tready, 0);
        check("mid_rst_flag", k_out_tdata[16], 0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        got_q.delete();
        det_q.delete();
        repeat (5) @(negedge aclk);
        check("stale_beats", got_q.size(), 0);
        check("stale_dets", det_q.size(), 0);
        @(posedge aclk);
        #1;
        run_frame(3, 1'b1, 50, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
